// File: rtl/mdu_pkg.sv
// Shared constants and encodings for the iterative multiply/divide unit.
package mdu_pkg;

  localparam int WIDTH = 32;
  localparam int ITER  = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_CALC   = 2'b01,
    ST_FINISH = 2'b10
  } state_t;

endpackage

// File: rtl/mult_div_unit.sv
// Radix-2 multiply/divide unit: one shared 64-bit accumulator and one 33-bit adder,
// magnitudes computed on capture, sign fix-up and HI/LO write-back in FINISH.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CNT_W = $clog2(ITER);

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_d(input logic [2*WIDTH-1:0] v);
    return ~v + (2*WIDTH)'(1);
  endfunction

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_fix;
  logic                 r_mul;
  logic                 r_neg_lo;
  logic                 r_neg_hi;
  logic [WIDTH-1:0]     r_b;
  logic [2*WIDTH-1:0]   r_acc;
  logic                 r_busy;
  logic                 r_done;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;

  logic                 w_signed;
  logic                 w_mul_op;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [WIDTH:0]       w_add_a;
  logic [WIDTH:0]       w_add_b;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_fix;

  assign w_signed = (op == OP_MULT) || (op == OP_DIV);
  assign w_mul_op = (op == OP_MULT) || (op == OP_MULTU);
  assign w_a_mag  = (w_signed && in1[WIDTH-1]) ? neg_w(in1) : in1;
  assign w_b_mag  = (w_signed && in2[WIDTH-1]) ? neg_w(in2) : in2;

  // Multiply adds the multiplicand to the high half; divide subtracts the divisor
  // from the high half shifted left by one (33 bits, so the borrow lands in bit 32).
  assign w_add_a = r_mul ? {1'b0, r_acc[2*WIDTH-1:WIDTH]} : r_acc[2*WIDTH-1:WIDTH-1];
  assign w_add_b = r_mul ? {1'b0, r_b} : ~{1'b0, r_b};
  assign w_sum   = w_add_a + w_add_b + {{WIDTH{1'b0}}, ~r_mul};

  assign w_fix = r_mul ? (r_neg_lo ? neg_d(r_acc) : r_acc)
                       : {(r_neg_hi ? neg_w(r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH]),
                          (r_neg_lo ? neg_w(r_acc[WIDTH-1:0])       : r_acc[WIDTH-1:0])};

  assign busy = r_busy;
  assign done = r_done;
  assign HI   = r_hi;
  assign LO   = r_lo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_fix    <= 1'b0;
      r_mul    <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_b      <= '0;
      r_acc    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_busy <= 1'b0;
          if (start) begin
            r_mul    <= w_mul_op;
            r_acc    <= {{WIDTH{1'b0}}, (w_mul_op ? w_b_mag : w_a_mag)};
            r_b      <= w_mul_op ? w_a_mag : w_b_mag;
            // A zero divisor keeps the all-ones quotient unsigned.
            r_neg_lo <= w_signed && (in1[WIDTH-1] ^ in2[WIDTH-1]) && (w_mul_op || (in2 != '0));
            r_neg_hi <= w_signed && in1[WIDTH-1] && !w_mul_op;
            r_cnt    <= CNT_W'(ITER - 1);
            r_fix    <= 1'b0;
            r_state  <= ST_CALC;
          end else begin
            if (mthi) r_hi <= in1;
            if (mtlo) r_lo <= in1;
          end
        end
        ST_CALC: begin
          r_busy <= 1'b1;
          if (r_mul)
            r_acc <= r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]};
          else
            r_acc <= w_sum[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                  : {w_sum[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
          if (r_cnt == '0) r_state <= ST_FINISH;
          else             r_cnt   <= r_cnt - CNT_W'(1);
        end
        ST_FINISH: begin
          // First FINISH cycle applies the sign fix-up, the second publishes it.
          if (!r_fix) begin
            r_acc  <= w_fix;
            r_fix  <= 1'b1;
            r_busy <= 1'b1;
          end else begin
            r_hi    <= r_acc[2*WIDTH-1:WIDTH];
            r_lo    <= r_acc[WIDTH-1:0];
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_fix   <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected results queued at start, checked on done.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;

  typedef struct {
    logic [63:0] res;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   bcnt  = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .in1(in1), .in2(in2),
    .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done), .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb64;
    int          qa, qb;
    sa   = {{32{a[31]}}, a};
    sb64 = {{32{b[31]}}, b};
    case (o)
      OP_MULT:  return sa * sb64;
      OP_MULTU: return {32'h0, a} * {32'h0, b};
      OP_DIV: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        qa = a;
        qb = b;
        return {32'(qa % qb), 32'(qa / qb)};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Monitor: checks each done against the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        bcnt = 0;
      end else if (done) begin
        chk("busy_at_done", 64'(busy), 64'd0);
        if (sb.size() == 0) begin
          chk("spurious_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("HI", 64'(HI), 64'(e.res[63:32]));
          chk("LO", 64'(LO), 64'(e.res[31:0]));
          chk("latency", 64'(cyc), 64'(e.cyc));
          chk("busy_cycles", 64'(bcnt), 64'd33);
        end
        bcnt = 0;
      end else if (busy) begin
        bcnt++;
      end
    end
  end

  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    start = 1'b1;
    op    = o;
    in1   = a;
    in2   = b;
    e.res = model(o, a, b);
    e.cyc = cyc + 1 + 34;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    in1   = $urandom;
    in2   = $urandom;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_done(output int d);
    d = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done) begin
        d = cyc;
        break;
      end
    end
    if (d < 0) chk("done_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] lo_keep, hi_keep;
    int d1, d2;
    rst = 1'b1; start = 1'b0; op = 2'b00; in1 = '0; in2 = '0; mthi = 1'b0; mtlo = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_HI",   64'(HI),   64'd0);
    chk("rst_LO",   64'(LO),   64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // first start right at the first edge after release
    do_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle();
    chk("multu_max_HI", 64'(HI), 64'h00000000FFFFFFFE);
    chk("multu_max_LO", 64'(LO), 64'h0000000000000001);

    do_op(OP_MULT, 32'hFFFFFFFD, 32'h00000005); wait_idle();
    do_op(OP_DIV,  32'hFFFFFFF9, 32'h00000002); wait_idle();
    do_op(OP_DIVU, 32'h00000007, 32'h00000000); wait_idle();
    do_op(OP_DIV,  32'h80000000, 32'hFFFFFFFF); wait_idle();
    do_op(OP_DIV,  32'h80000005, 32'h00000000); wait_idle();
    do_op(OP_MULT, 32'h80000000, 32'h80000000); wait_idle();
    do_op(OP_DIV,  32'h00000007, 32'hFFFFFFFE); wait_idle();
    do_op(OP_DIVU, 32'hFFFFFFFF, 32'h00000003); wait_idle();

    // start/mthi/mtlo pulses while busy are ignored
    do_op(OP_MULTU, 32'h0001E240, 32'h00003039);
    repeat (5) @(negedge clk);
    start = 1'b1; mthi = 1'b1; mtlo = 1'b1; op = OP_DIV; in1 = 32'hDEADBEEF; in2 = 32'h3;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    wait_idle();

    // mthi / mtlo in IDLE
    lo_keep = LO;
    in1 = 32'h12345678; mthi = 1'b1;
    @(negedge clk);
    mthi = 1'b0;
    chk("mthi_HI", 64'(HI), 64'h12345678);
    chk("mthi_LO", 64'(LO), 64'(lo_keep));
    in1 = 32'hA5A5C3C3; mthi = 1'b1; mtlo = 1'b1;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    chk("both_HI", 64'(HI), 64'hA5A5C3C3);
    chk("both_LO", 64'(LO), 64'hA5A5C3C3);

    // start wins over mthi in the same cycle
    hi_keep = HI;
    mthi = 1'b1;
    do_op(OP_MULTU, 32'd6, 32'd7);
    mthi = 1'b0;
    chk("start_prio_HI", 64'(HI), 64'(hi_keep));
    wait_idle();

    // random operations
    for (int i = 0; i < 8; i++) begin
      do_op(2'($urandom_range(0, 3)), $urandom, (i == 3) ? 32'h0 : $urandom);
      wait_idle();
    end

    // back-to-back: second start in the done cycle
    do_op(OP_DIVU, 32'd1000, 32'd7);
    wait_done(d1);
    do_op(OP_MULT, 32'hFFFFFFFF, 32'd9);
    wait_done(d2);
    chk("b2b_gap", 64'(d2 - d1), 64'd35);
    wait_idle();

    // asynchronous reset mid-operation aborts with no done
    do_op(OP_DIVU, 32'hFFFF0000, 32'd13);
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_HI",   64'(HI),   64'd0);
    chk("abort_LO",   64'(LO),   64'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    do_op(OP_MULTU, 32'd3, 32'd4);
    wait_idle();
    chk("post_rst_LO", 64'(LO), 64'd12);
    chk("post_rst_HI", 64'(HI), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
